// File: rtl/bw_pkg.sv
// Shared bit-width defaults for the threshold search and the downstream
// interpolator, so both sides agree on bin-index and dB sample formats.
package bw_pkg;

    localparam int BW_FREQ_BIN_WIDTH = 9;
    localparam int BW_ACCUM_WIDTH    = 16;
    localparam int BW_THRESHOLD_DB   = 30;

endpackage : bw_pkg

// File: rtl/threshold_crossing_search.sv
// Scans one spectrum frame per pass for the first bin that falls below
// -THRESHOLD_DB, captures the bracketing bins/levels and hands them to the interpolator.
module threshold_crossing_search
    import bw_pkg::*;
#(
    parameter int FREQ_BIN_WIDTH = BW_FREQ_BIN_WIDTH,
    parameter int ACCUM_WIDTH    = BW_ACCUM_WIDTH,
    parameter int THRESHOLD_DB   = BW_THRESHOLD_DB,
    parameter int NUM_BINS       = 512
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [ACCUM_WIDTH-1:0]    s_data_i,
    input  logic                      s_last_i,
    input  logic                      busy_i,
    output logic                      start_o,
    output logic [FREQ_BIN_WIDTH-1:0] f1_o,
    output logic [FREQ_BIN_WIDTH-1:0] f2_o,
    output logic [ACCUM_WIDTH-1:0]    L1_o,
    output logic [ACCUM_WIDTH-1:0]    L2_o,
    output logic                      found_o,
    output logic                      len_err_o
);

    typedef enum logic [2:0] {
        SCAN,
        DRAIN,
        WAIT_DS,
        START,
        WAIT_DONE
    } state_e;

    localparam logic signed [ACCUM_WIDTH-1:0] THR = ACCUM_WIDTH'(-THRESHOLD_DB);
    localparam logic [FREQ_BIN_WIDTH-1:0]     LAST_BIN = FREQ_BIN_WIDTH'(NUM_BINS - 1);

    state_e                    state_q, state_d;
    logic                      start_q, start_d;
    logic [FREQ_BIN_WIDTH-1:0] bin_cnt_q;
    logic [ACCUM_WIDTH-1:0]    prev_q;
    logic [FREQ_BIN_WIDTH-1:0] f1_q, f2_q;
    logic [ACCUM_WIDTH-1:0]    L1_q, L2_q;
    logic                      found_q;
    logic                      len_err_q;

    logic accept;
    logic below;
    logic at_max;
    logic frame_end;

    assign accept    = s_valid_i & s_ready_o;
    assign below     = $signed(s_data_i) < THR;
    assign at_max    = (bin_cnt_q == LAST_BIN);
    assign frame_end = accept & (s_last_i | at_max);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SCAN;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SCAN: begin
                if (frame_end)           state_d = WAIT_DS;
                else if (accept && below) state_d = DRAIN;
            end
            DRAIN:     if (frame_end) state_d = WAIT_DS;
            WAIT_DS:   if (!busy_i)   state_d = START;
            START:                    state_d = WAIT_DONE;
            WAIT_DONE: if (!busy_i)   state_d = SCAN;
            default:                  state_d = SCAN;
        endcase
    end

    always_comb begin
        s_ready_o = (state_q == SCAN) || (state_q == DRAIN);
        start_d   = (state_d == START);
    end

    // While still in SCAN every earlier bin was at/above threshold, so a
    // below-threshold sample here is by construction the first crossing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_cnt_q <= '0;
            prev_q    <= '0;
            f1_q      <= '0;
            f2_q      <= '0;
            L1_q      <= '0;
            L2_q      <= '0;
            found_q   <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= accept & at_max & ~s_last_i;
            if (accept) begin
                bin_cnt_q <= frame_end ? '0 : bin_cnt_q + FREQ_BIN_WIDTH'(1);
            end
            if (accept && state_q == SCAN) begin
                prev_q <= s_data_i;
                if (below) begin
                    f1_q    <= (bin_cnt_q == '0) ? '0 : bin_cnt_q - FREQ_BIN_WIDTH'(1);
                    f2_q    <= bin_cnt_q;
                    L1_q    <= (bin_cnt_q == '0) ? s_data_i : prev_q;
                    L2_q    <= s_data_i;
                    found_q <= 1'b1;
                end else if (frame_end) begin
                    f1_q    <= bin_cnt_q;
                    f2_q    <= bin_cnt_q;
                    L1_q    <= s_data_i;
                    L2_q    <= s_data_i;
                    found_q <= 1'b0;
                end
            end
        end
    end

    assign start_o   = start_q;
    assign f1_o      = f1_q;
    assign f2_o      = f2_q;
    assign L1_o      = L1_q;
    assign L2_o      = L2_q;
    assign found_o   = found_q;
    assign len_err_o = len_err_q;

endmodule : threshold_crossing_search

// File: tb/tb_threshold_crossing_search.sv
// Self-checking bench: directed vector table, busy/reset sequences, and
// random frames compared against a first-crossing reference model.
module tb_threshold_crossing_search;

    localparam int FW  = 9;
    localparam int AW  = 16;
    localparam int NB  = 8;
    localparam int THR = 30;

    typedef struct {
        int f1;
        int f2;
        int L1;
        int L2;
        bit found;
    } exp_t;

    typedef struct {
        int   len;
        int   d[8];
        bit   drop_last;
        exp_t e;
        bit   elen;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          busy = 1'b0;
    logic          start;
    logic [FW-1:0] f1, f2;
    logic [AW-1:0] L1, L2;
    logic          found;
    logic          len_err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int fd[8];

    threshold_crossing_search #(
        .FREQ_BIN_WIDTH(FW),
        .ACCUM_WIDTH   (AW),
        .THRESHOLD_DB  (THR),
        .NUM_BINS      (NB)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .s_data_i (s_data),
        .s_last_i (s_last),
        .busy_i   (busy),
        .start_o  (start),
        .f1_o     (f1),
        .f2_o     (f2),
        .L1_o     (L1),
        .L2_o     (L2),
        .found_o  (found),
        .len_err_o(len_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (start) start_cnt++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the first bin below -THR; bin 0 brackets itself; no crossing -> last bin.
    function automatic exp_t model(input int len, input int d[8]);
        exp_t r;
        int   e;
        e = (len < NB ? len : NB) - 1;
        r = '{f1: e, f2: e, L1: d[e], L2: d[e], found: 1'b0};
        for (int k = 0; k <= e; k++) begin
            if (d[k] < -THR) begin
                r.f1    = (k == 0) ? 0 : k - 1;
                r.f2    = k;
                r.L1    = (k == 0) ? d[0] : d[k-1];
                r.L2    = d[k];
                r.found = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    // Sends fd[0..n-1]; returns #1 after the edge that accepted the final sample.
    task automatic send_frame(input int n, input bit last_on_final, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int budget;
            bit ok;
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_data  = AW'(fd[i]);
            s_last  = (i == n - 1) && last_on_final;
            ok = 1'b0;
            budget = 20;
            while (!ok && budget > 0) begin
                ok = s_ready;
                tick();
                budget--;
            end
            if (!ok) chk("accept_timeout", 0, 1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, ".f1"}, int'(f1), e.f1);
        chk({tag, ".f2"}, int'(f2), e.f2);
        chk({tag, ".L1"}, int'($signed(L1)), e.L1);
        chk({tag, ".L2"}, int'($signed(L2)), e.L2);
        chk({tag, ".found"}, int'(found), int'(e.found));
    endtask

    // Full frame with busy low: start_o appears exactly two cycles after the last acceptance.
    task automatic run_frame(input string tag, input int len, input bit drop, input bit gaps,
                             input exp_t e, input bit elen);
        send_frame(len, !drop, gaps);
        chk({tag, ".ready_ds"}, int'(s_ready), 0);
        chk({tag, ".start_early"}, int'(start), 0);
        chk({tag, ".len_err"}, int'(len_err), int'(elen));
        tick();
        chk({tag, ".start"}, int'(start), 1);
        chk({tag, ".len_err_clr"}, int'(len_err), 0);
        chk_outputs(tag, e);
        tick();
        chk({tag, ".start_pulse"}, int'(start), 0);
        tick();
        chk({tag, ".ready_back"}, int'(s_ready), 1);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{len: 6, d: '{0, -5, -20, -29, -31, -40, 0, 0}, drop_last: 1'b0,
                   e: '{f1: 3, f2: 4, L1: -29, L2: -31, found: 1'b1}, elen: 1'b0};
        tbl[1] = '{len: 2, d: '{-35, -40, 0, 0, 0, 0, 0, 0}, drop_last: 1'b0,
                   e: '{f1: 0, f2: 0, L1: -35, L2: -35, found: 1'b1}, elen: 1'b0};
        tbl[2] = '{len: 3, d: '{0, -10, -20, 0, 0, 0, 0, 0}, drop_last: 1'b0,
                   e: '{f1: 2, f2: 2, L1: -20, L2: -20, found: 1'b0}, elen: 1'b0};
        tbl[3] = '{len: 4, d: '{-1, -2, -30, -31, 0, 0, 0, 0}, drop_last: 1'b0,
                   e: '{f1: 2, f2: 3, L1: -30, L2: -31, found: 1'b1}, elen: 1'b0};
        tbl[4] = '{len: 8, d: '{0, -1, -2, -3, -4, -5, -6, -7}, drop_last: 1'b1,
                   e: '{f1: 7, f2: 7, L1: -7, L2: -7, found: 1'b0}, elen: 1'b1};
        tbl[5] = '{len: 1, d: '{-30, 0, 0, 0, 0, 0, 0, 0}, drop_last: 1'b0,
                   e: '{f1: 0, f2: 0, L1: -30, L2: -30, found: 1'b0}, elen: 1'b0};
        tbl[6] = '{len: 8, d: '{-3, -3, -3, -3, -3, -3, -10, -31}, drop_last: 1'b0,
                   e: '{f1: 6, f2: 7, L1: -10, L2: -31, found: 1'b1}, elen: 1'b0};

        #12;
        chk("rst.start", int'(start), 0);
        chk("rst.found", int'(found), 0);
        chk("rst.len_err", int'(len_err), 0);
        chk("rst.f1", int'(f1), 0);
        chk("rst.L2", int'(L2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst.ready", int'(s_ready), 1);

        foreach (tbl[i]) begin
            fd = tbl[i].d;
            run_frame($sformatf("vec%0d", i), tbl[i].len, tbl[i].drop_last, 1'b0,
                      tbl[i].e, tbl[i].elen);
        end

        // Busy held high for 10 cycles after frame end; crossing at bin 4.
        begin
            exp_t e;
            fd = '{0, -1, -2, -30, -31, -40, 0, 0};
            e  = model(6, fd);
            busy = 1'b1;
            send_frame(6, 1'b1, 1'b0);
            for (int c = 0; c < 10; c++) begin
                chk("busy.start", int'(start), 0);
                chk("busy.ready", int'(s_ready), 0);
                chk("busy.f1", int'(f1), e.f1);
                chk("busy.L2", int'($signed(L2)), e.L2);
                tick();
            end
            busy = 1'b0;
            tick();
            chk("busy.start_after", int'(start), 1);
            chk_outputs("busy", e);
            busy = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick();
                chk("busy.done_ready", int'(s_ready), 0);
                chk("busy.done_found", int'(found), 1);
            end
            busy = 1'b0;
            tick();
            chk("busy.ready_back", int'(s_ready), 1);
        end

        // Reset mid-frame at bin 3 abandons the frame; the next frame restarts at bin 0.
        begin
            int sc;
            fd = '{0, -1, -2, -3, 0, 0, 0, 0};
            send_frame(3, 1'b0, 1'b0);
            sc = start_cnt;
            s_valid = 1'b1;
            s_data  = AW'(-3);
            #2 rst_n = 1'b0;
            #1;
            chk("mrst.found", int'(found), 0);
            chk("mrst.f2", int'(f2), 0);
            s_valid = 1'b0;
            tick();
            tick();
            rst_n = 1'b1;
            for (int c = 0; c < 8; c++) tick();
            chk("mrst.no_start", start_cnt, sc);
            chk("mrst.ready", int'(s_ready), 1);
            fd = '{0, -40, 0, 0, 0, 0, 0, 0};
            run_frame("mrst.next", 2, 1'b0, 1'b0, model(2, fd), 1'b0);
        end

        for (int t = 0; t < 40; t++) begin
            int  len;
            bit  drop;
            len = $urandom_range(1, NB);
            drop = (len == NB) && ($urandom_range(0, 1) == 1);
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 3) == 0) fd[k] = -29 - int'($urandom_range(0, 3));
                else                           fd[k] = int'($urandom_range(0, 70)) - 50;
            end
            run_frame($sformatf("rnd%0d", t), len, drop, 1'b1, model(len, fd), drop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_threshold_crossing_search

// File: doc/threshold_crossing_search.md
THRESHOLD_CROSSING_SEARCH -- requirements
Module: threshold_crossing_search

Interface
REQ-001 SHALL have parameter FREQ_BIN_WIDTH, default 9: bin index width.
REQ-002 SHALL have parameter ACCUM_WIDTH, default 16: signed dB sample width.
REQ-003 SHALL have parameter THRESHOLD_DB, default 30: crossing level is -THRESHOLD_DB.
REQ-004 SHALL have parameter NUM_BINS, default 512: maximum bins per frame, ≤ 2^FREQ_BIN_WIDTH.
REQ-005 SHALL have ports:
  - clk_i  in  1  clock.
  - rst_ni  in  1  reset, asynchronous, active-low.
  - s_valid_i  in  1  spectrum sample valid.
  - s_ready_o  out  1  sample accepted when s_valid_i and s_ready_o are both high.
  - s_data_i  in  ACCUM_WIDTH  signed normalized dB, peak = 0.
  - s_last_i  in  1  last bin of frame.
  - busy_i  in  1  downstream interpolator busy.
  - start_o  out  1  one-cycle start pulse to the interpolator.
  - f1_o, f2_o  out  FREQ_BIN_WIDTH each  bracketing bins.
  - L1_o, L2_o  out  ACCUM_WIDTH each  levels at f1 and f2.
  - found_o  out  1  crossing found in the frame.
  - len_err_o  out  1  one-cycle pulse on frame-length overrun.

Function
REQ-006 SHALL keep a bin counter that is 0 at the first accepted sample of each frame and increments per accepted sample.
REQ-007 SHALL define the crossing as the first bin k ≥ 1 with s_data < -THRESHOLD_DB (signed compare) while the previous bin is ≥ -THRESHOLD_DB.
REQ-008 SHALL, on the crossing, capture f1=k-1, f2=k, L1=previous sample, L2=current sample, and found=1.
REQ-009 SHALL, if bin 0 is already below threshold, capture f1=f2=0, L1=L2=bin-0 sample, and found=1.
REQ-010 SHALL, if no crossing occurs by end of frame, capture f1=f2=last bin index, L1=L2=last sample, and found=0.
REQ-011 SHALL use FSM states SCAN, DRAIN, WAIT_DS, START, WAIT_DONE.
REQ-012 SCAN: s_ready_o=1, search active; on crossing go to DRAIN, or go to WAIT_DS if that sample is also the frame end.
REQ-013 SCAN: at frame end with no crossing, go to WAIT_DS.
REQ-014 DRAIN: s_ready_o=1; discard samples without changing captured values; go to WAIT_DS at frame end.
REQ-015 WAIT_DS: s_ready_o=0; go to START on the first cycle with busy_i=0.
REQ-016 START: start_o=1 for exactly one cycle; then go to WAIT_DONE.
REQ-017 WAIT_DONE: s_ready_o=0; go to SCAN on the first cycle with busy_i=0.
REQ-018 Frame end SHALL be an accepted sample with s_last_i=1, or the accepted sample at bin NUM_BINS-1, whichever comes first.
REQ-019 If bin NUM_BINS-1 is accepted with s_last_i=0, SHALL pulse len_err_o for one cycle and treat that sample as the frame end.
REQ-020 f1_o, f2_o, L1_o, L2_o, found_o SHALL be registered and change only on a capture, so they are stable from start_o until return to SCAN.
REQ-021 start_o SHALL be a registered Moore output, asserted only in START.
REQ-022 s_ready_o SHALL be derived from state only, with no combinational path from s_valid_i.
REQ-023 Latency: start_o SHALL assert 2 cycles after the frame-end acceptance when busy_i=0.
REQ-024 Previous-sample register SHALL update on every accepted sample in SCAN.

Reset
REQ-025 rst_ni low SHALL force state SCAN, bin counter 0, and all captured registers 0.
REQ-026 rst_ni low SHALL force start_o=0, found_o=0, len_err_o=0.
REQ-027 After reset release, s_ready_o SHALL be 1.
REQ-028 Reset mid-frame SHALL abandon the frame with no start_o; the next accepted sample is bin 0.

Structure
REQ-029 FREQ_BIN_WIDTH, ACCUM_WIDTH, THRESHOLD_DB defaults SHALL live in shared package bw_pkg, also used by the interpolator.
REQ-030 The FSM state enum SHALL stay local to the module.
REQ-031 No sub-module: single flat module with one comparator and one counter.

Verification
REQ-032 Frame [0,-5,-20,-29,-31,-40], last at bin 5, busy_i=0 -> f1=3, f2=4, L1=-29, L2=-31, found=1, start_o 2 cycles after last.
REQ-033 Frame [-35,-40] -> f1=f2=0, L1=L2=-35, found=1.
REQ-034 Frame [0,-10,-20] -> f1=f2=2, L1=L2=-20, found=0.
REQ-035 Crossing at bin 4, busy_i held high 10 cycles after frame end -> start_o only after busy_i falls; outputs stable; s_ready_o=0 throughout.
REQ-036 Level exactly -30 at bin 2 then -31 -> crossing at f1=2, f2=3 (-30 is not below threshold).
REQ-037 NUM_BINS=8 with s_last_i never asserted -> len_err_o pulses at bin 7, frame closes; reset at bin 3 of the next frame -> no start_o.
